output_mem_acc: RTL and testbench

- Parametrised successor to the dual-port output memory: N_CH request channels into one DEPTH x DATA_W output buffer, replacing the split load/write clock-phase scheme with a single-clock pipeline.
- Adds lane-wise saturating accumulate (read-modify-write of partial sums), overwrite, a streaming scan-in/scan-out FSM with an auto-incrementing pointer, and a bulk clear.
- Sits between the CIM array / controller and the scan chain.

---
 rtl/output_mem_acc.sv | 209 ++++++++++++++++++++
 tb/tb_output_mem_acc.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_mem_acc.sv
// rtl/output_mem_acc.sv - multi-channel output buffer with saturating accumulate, scan FSM and bulk clear
module output_mem_acc #(
  parameter int DATA_W = 512,
  parameter int LANE_W = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int N_CH   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     clear_start,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_data,
  output logic                     req_ready,
  output logic [N_CH-1:0]          rsp_valid,
  output logic [N_CH*ADDR_W-1:0]   rsp_addr,
  output logic [N_CH*DATA_W-1:0]   rsp_data,
  input  logic                     scan_in_valid,
  input  logic [DATA_W-1:0]        scan_in,
  input  logic                     scan_out_start,
  output logic                     scan_out_valid,
  output logic [DATA_W-1:0]        scan_out,
  output logic                     scan_done,
  output logic                     busy
);

  localparam int N_LANE = DATA_W / LANE_W;
  localparam logic [1:0] M_SCAN_IN  = 2'b00;
  localparam logic [1:0] M_ACC      = 2'b01;
  localparam logic [1:0] M_WRITE    = 2'b10;
  localparam logic [1:0] M_SCAN_OUT = 2'b11;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN_OUT} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] scan_ptr;
  logic [1:0]        mode_q;
  logic              scan_wr;
  logic              clr_wr;

  logic [N_CH-1:0]   s1_valid;
  logic [ADDR_W-1:0] s1_addr [N_CH];
  logic [DATA_W-1:0] s1_data [N_CH];
  logic              s1_acc;
  logic [DATA_W-1:0] s1_new  [N_CH];
  logic [N_CH-1:0]   s1_inr;

  // Lane-wise signed add clamped to the lane range; lanes never carry into each other.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic [LANE_W:0]   s;
    r = '0;
    for (int l = 0; l < N_LANE; l++) begin
      s = {a[l*LANE_W+LANE_W-1], a[l*LANE_W +: LANE_W]} +
          {b[l*LANE_W+LANE_W-1], b[l*LANE_W +: LANE_W]};
      if (s[LANE_W] != s[LANE_W-1])
        r[l*LANE_W +: LANE_W] = s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                          : {1'b0, {(LANE_W-1){1'b1}}};
      else
        r[l*LANE_W +: LANE_W] = s[LANE_W-1:0];
    end
    return r;
  endfunction

  // Only matters when DEPTH is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(DEPTH);
  endfunction

  assign req_ready = (state == S_IDLE) && ((mode == M_ACC) || (mode == M_WRITE));

  // State, scan pointer and previous mode (for pointer reset on mode change).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= '0;
      mode_q <= M_SCAN_IN;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      mode_q <= mode;
    end
  end

  // Next-state, pointer stepping and scan/clear outputs.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    scan_ptr       = '0;
    scan_wr        = 1'b0;
    clr_wr         = 1'b0;
    scan_done      = 1'b0;
    scan_out_valid = 1'b0;
    scan_out       = '0;
    busy           = 1'b0;
    case (state)
      S_IDLE: begin
        // A mode change restarts the scan-in pointer from word 0.
        scan_ptr = (mode != mode_q) ? '0 : ptr;
        ptr_nxt  = scan_ptr;
        if (clear_start) begin
          state_nxt = S_CLEAR;
          ptr_nxt   = '0;
        end else if (scan_out_start && (mode == M_SCAN_OUT)) begin
          state_nxt = S_SCAN_OUT;
          ptr_nxt   = '0;
        end else if ((mode == M_SCAN_IN) && scan_in_valid) begin
          scan_wr = 1'b1;
          ptr_nxt = (scan_ptr == LAST) ? '0 : scan_ptr + 1'b1;
        end
      end
      S_CLEAR: begin
        busy   = 1'b1;
        clr_wr = 1'b1;
        if (ptr == LAST) begin
          scan_done = 1'b1;
          state_nxt = S_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      S_SCAN_OUT: begin
        busy           = 1'b1;
        scan_out_valid = 1'b1;
        scan_out       = mem[ptr];
        if (ptr == LAST) begin
          scan_done = 1'b1;
          state_nxt = S_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage 1: capture accepted requests together with the mode they were issued under.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= '0;
      s1_acc   <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        s1_addr[c] <= '0;
        s1_data[c] <= '0;
      end
    end else begin
      s1_valid <= req_ready ? req_valid : '0;
      s1_acc   <= (mode == M_ACC);
      for (int c = 0; c < N_CH; c++) begin
        s1_addr[c] <= req_addr[c*ADDR_W +: ADDR_W];
        s1_data[c] <= req_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Per-channel result: fold every colliding channel in ascending order, so ACC
  // saturates after each add and WRITE ends with the highest channel's data.
  always_comb begin
    logic [DATA_W-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) begin
      s1_inr[c] = in_range(s1_addr[c]);
      v = s1_inr[c] ? mem[s1_addr[c]] : '0;
      for (int j = 0; j < N_CH; j++) begin
        if (s1_valid[j] && (s1_addr[j] == s1_addr[c]))
          v = s1_acc ? sat_add(v, s1_data[j]) : s1_data[j];
      end
      s1_new[c] = s1_inr[c] ? v : '0;
    end
  end

  // Storage writes; colliding channels write the same value. A clear write
  // lands last so an in-flight request is overwritten by the clear that follows it.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (s1_valid[c] && s1_inr[c])
        mem[s1_addr[c]] <= s1_new[c];
    end
    if (scan_wr)
      mem[scan_ptr] <= scan_in;
    if (clr_wr)
      mem[ptr] <= '0;
  end

  // Response registers: echoed address and post-operation word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1_valid;
      for (int c = 0; c < N_CH; c++) begin
        rsp_addr[c*ADDR_W +: ADDR_W] <= s1_addr[c];
        rsp_data[c*DATA_W +: DATA_W] <= s1_new[c];
      end
    end
  end

endmodule

// File: tb/tb_output_mem_acc.sv
// tb/tb_output_mem_acc.sv - scoreboard bench for output_mem_acc
module tb_output_mem_acc;
  localparam int DATA_W = 512;
  localparam int LANE_W = 16;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int N_CH   = 2;
  localparam int NL     = DATA_W / LANE_W;
  localparam logic [1:0] M_SI = 2'b00, M_ACC = 2'b01, M_WR = 2'b10, M_SO = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [1:0]             mode;
  logic                   clear_start;
  logic [N_CH-1:0]        req_valid;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH*DATA_W-1:0] req_data;
  logic                   req_ready;
  logic [N_CH-1:0]        rsp_valid;
  logic [N_CH*ADDR_W-1:0] rsp_addr;
  logic [N_CH*DATA_W-1:0] rsp_data;
  logic                   scan_in_valid;
  logic [DATA_W-1:0]      scan_in;
  logic                   scan_out_start;
  logic                   scan_out_valid;
  logic [DATA_W-1:0]      scan_out;
  logic                   scan_done;
  logic                   busy;

  output_mem_acc #(.DATA_W(DATA_W), .LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .N_CH(N_CH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clear_start(clear_start),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .scan_in_valid(scan_in_valid), .scan_in(scan_in), .scan_out_start(scan_out_start),
    .scan_out_valid(scan_out_valid), .scan_out(scan_out), .scan_done(scan_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [N_CH-1:0]        mask;
    logic [N_CH*ADDR_W-1:0] addr;
    logic [N_CH*DATA_W-1:0] data;
    int                     cyc;
  } rsp_t;
  typedef struct {
    logic [DATA_W-1:0] word;
    logic              done;
  } scan_t;

  rsp_t  rq[$];
  scan_t sq[$];
  logic [DATA_W-1:0] model [DEPTH];
  int beats = 0;
  rsp_t  me;
  scan_t ms;

  function automatic logic [DATA_W-1:0] m_sat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    int s;
    int hi, lo;
    hi = (1 << (LANE_W - 1)) - 1;
    lo = -(1 << (LANE_W - 1));
    r = '0;
    for (int l = 0; l < NL; l++) begin
      s = int'($signed(a[l*LANE_W +: LANE_W])) + int'($signed(b[l*LANE_W +: LANE_W]));
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      r[l*LANE_W +: LANE_W] = s[LANE_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rep(input logic [LANE_W-1:0] v);
    return {NL{v}};
  endfunction

  // Monitor: pop and compare scoreboard entries as outputs appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid != '0) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", DATA_W'(rsp_valid), '0);
        end else begin
          me = rq.pop_front();
          chk("rsp_valid", DATA_W'(rsp_valid), DATA_W'(me.mask));
          chk("rsp_latency", DATA_W'(cyc), DATA_W'(me.cyc));
          for (int c = 0; c < N_CH; c++) begin
            if (me.mask[c]) begin
              chk("rsp_data", rsp_data[c*DATA_W +: DATA_W], me.data[c*DATA_W +: DATA_W]);
              chk("rsp_addr", DATA_W'(rsp_addr[c*ADDR_W +: ADDR_W]), DATA_W'(me.addr[c*ADDR_W +: ADDR_W]));
            end
          end
        end
      end
      if (scan_out_valid) begin
        beats++;
        if (sq.size() == 0) begin
          chk("scan_unexpected", DATA_W'(scan_out_valid), '0);
        end else begin
          ms = sq.pop_front();
          chk("scan_word", scan_out, ms.word);
          chk("scan_done_beat", DATA_W'(scan_done), DATA_W'(ms.done));
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = '0; clear_start = 1'b0; scan_out_start = 1'b0; scan_in_valid = 1'b0;
    end
  endtask

  // One request cycle; the model applies channels in ascending order.
  task automatic req(input logic [1:0] md, input logic [N_CH-1:0] m,
                     input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                     input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    rsp_t e;
    logic [ADDR_W-1:0] a [N_CH];
    logic [DATA_W-1:0] d [N_CH];
    @(posedge clk); #1;
    mode = md; req_valid = m; req_addr = {a1, a0}; req_data = {d1, d0};
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    for (int c = 0; c < N_CH; c++)
      if (m[c]) model[a[c]] = (md == M_ACC) ? m_sat(model[a[c]], d[c]) : d[c];
    e.mask = m; e.addr = {a1, a0}; e.data = '0; e.cyc = cyc + 2;
    for (int c = 0; c < N_CH; c++)
      if (m[c]) e.data[c*DATA_W +: DATA_W] = model[a[c]];
    rq.push_back(e);
  endtask

  task automatic drain_rsp;
    for (int i = 0; i < 20 && rq.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("rsp_drain", DATA_W'(rq.size()), '0);
  endtask

  task automatic do_clear;
    int n0, dt;
    logic found;
    found = 1'b0; dt = -1;
    @(posedge clk); #1;
    clear_start = 1'b1; n0 = cyc;
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int i = 0; i < DEPTH + 20 && !found; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_in_clear", DATA_W'(busy), DATA_W'(1));
      if (scan_done) begin
        found = 1'b1; dt = cyc - n0;
      end
    end
    chk("clear_done_seen", DATA_W'(found), DATA_W'(1));
    chk("clear_cycles", DATA_W'(dt), DATA_W'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    idle_cycles(1);
  endtask

  task automatic do_scan_out;
    scan_t s;
    int b0;
    @(posedge clk); #1;
    mode = M_SO; scan_out_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      s.word = model[i]; s.done = (i == DEPTH - 1);
      sq.push_back(s);
    end
    b0 = beats;
    @(posedge clk); #1;
    scan_out_start = 1'b0;
    for (int i = 0; i < DEPTH + 20 && sq.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("scan_drain", DATA_W'(sq.size()), '0);
    chk("scan_beats", DATA_W'(beats - b0), DATA_W'(DEPTH));
    @(negedge clk);
    chk("busy_after_scan", DATA_W'(busy), '0);
  endtask

  logic [DATA_W-1:0] w0, w1;
  int b0;
  logic seen;

  initial begin
    rst_n = 1'b0; mode = M_SI; clear_start = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    scan_in_valid = 1'b0; scan_in = '0; scan_out_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", DATA_W'(busy), '0);
    chk("rst_req_ready", DATA_W'(req_ready), '0);
    chk("rst_rsp_valid", DATA_W'(rsp_valid), '0);
    chk("rst_rsp_data0", rsp_data[DATA_W-1:0], '0);
    chk("rst_scan_valid", DATA_W'(scan_out_valid), '0);
    chk("rst_scan_out", scan_out, '0);
    chk("rst_scan_done", DATA_W'(scan_done), '0);
    rst_n = 1'b1;

    do_clear();
    do_scan_out();

    // Scan-in 130 words of value=index; the pointer wraps onto words 0 and 1.
    @(posedge clk); #1;
    mode = M_SI;
    idle_cycles(2);
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(posedge clk); #1;
      scan_in_valid = 1'b1; scan_in = DATA_W'(i);
      model[i % DEPTH] = DATA_W'(i);
    end
    idle_cycles(1);
    do_scan_out();

    // Overwrite then four back-to-back accumulates of +3.
    req(M_WR, 2'b01, 7'd5, '0, 7'd0, '0);
    for (int k = 0; k < 4; k++) req(M_ACC, 2'b01, 7'd5, rep(16'h0003), 7'd0, '0);
    idle_cycles(1);
    drain_rsp();

    // Saturation per lane with unaffected neighbours.
    w0 = rep(16'h0100);
    w0[15:0] = 16'h7FF0; w0[31:16] = 16'h8005; w0[47:32] = 16'h1234;
    w1 = '0;
    w1[15:0] = 16'h0020; w1[31:16] = 16'hFFF0; w1[47:32] = 16'h0001;
    req(M_WR, 2'b01, 7'd20, w0, 7'd0, '0);
    req(M_ACC, 2'b01, 7'd20, w1, 7'd0, '0);
    idle_cycles(1);
    drain_rsp();
    chk("sat_model_lane0", model[20][15:0], 16'h7FFF);
    chk("sat_model_lane1", model[20][31:16], 16'h8000);

    // Same-address collisions, an ordered-saturation collision and independent channels.
    req(M_WR, 2'b01, 7'd9, '0, 7'd0, '0);
    req(M_ACC, 2'b11, 7'd9, rep(16'h0001), 7'd9, rep(16'h0002));
    req(M_WR, 2'b11, 7'd9, rep(16'hAAAA), 7'd9, rep(16'hBBBB));
    req(M_WR, 2'b01, 7'd12, rep(16'h7FF0), 7'd0, '0);
    req(M_ACC, 2'b11, 7'd12, rep(16'h0020), 7'd12, rep(16'hFFF0));
    req(M_ACC, 2'b11, 7'd30, rep(16'hFFFE), 7'd31, rep(16'h0005));
    req(M_WR, 2'b10, 7'd0, '0, 7'd127, rep(16'h5A5A));
    idle_cycles(1);
    drain_rsp();
    do_scan_out();

    // Reset in the middle of a scan-out aborts it.
    @(posedge clk); #1;
    mode = M_SO; scan_out_start = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ms.word = model[i]; ms.done = (i == DEPTH - 1);
      sq.push_back(ms);
    end
    b0 = beats;
    @(posedge clk); #1;
    scan_out_start = 1'b0;
    for (int i = 0; i < 200 && (beats - b0) < 50; i++) begin
      @(negedge clk); #1;
    end
    chk("abort_beats", DATA_W'(beats - b0), DATA_W'(50));
    #2;
    rst_n = 1'b0;
    #1;
    sq.delete();
    chk("abort_scan_valid", DATA_W'(scan_out_valid), '0);
    chk("abort_scan_out", scan_out, '0);
    chk("abort_scan_done", DATA_W'(scan_done), '0);
    chk("abort_busy", DATA_W'(busy), '0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (scan_done || scan_out_valid) seen = 1'b1;
    end
    chk("abort_no_done", DATA_W'(seen), '0);
    chk("post_busy", DATA_W'(busy), '0);
    chk("post_ready_so", DATA_W'(req_ready), '0);
    mode = M_ACC; #1;
    chk("post_ready_acc", DATA_W'(req_ready), DATA_W'(1));
    mode = M_WR; #1;
    chk("post_ready_wr", DATA_W'(req_ready), DATA_W'(1));
    mode = M_SI; #1;
    chk("post_ready_si", DATA_W'(req_ready), '0);

    chk("final_rq_empty", DATA_W'(rq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
